// File: rtl/psmac_acc.sv
// -----------------------------------------------------------------------------
// psmac_acc -- precision-scalable multiply-accumulate engine
//
// Multiplies LANES byte-lanes of activations (ip) by weights (wt) at a per-beat
// precision: one 8bx8b, two 4bx4b or four 2bx2b products per lane. All products
// of a beat are reduced to one beat sum. Beat sums are accumulated into packets
// closed by in_last. Three pipeline stages:
//   S1 : per-lane sums registered
//   S2 : cross-lane beat sum registered
//   S3 : beat sum added to the running accumulator; a last beat loads acc_out
//
// Parameters
//   LANES  number of 8-bit lanes (>= 1)
//   ACC_W  accumulator / result width
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   in_valid/in_ready   input beat handshake (in_ready depends on out_* only)
//   ip, wt              operands, lane i = [8i+7:8i]
//   mode                00 8b, 01 4b, 10 2b, 11 treated as 8b
//   sgn_ip, sgn_wt      sub-fields are two's complement when 1
//   in_last             beat closes the current packet
//   out_valid/out_ready result handshake
//   acc_out             signed packet result
//   ovf                 saturation occurred in this packet
//
// Build option
//   PSMAC_SAT_EN  defined   : each accumulator add clamps to signed ACC_W
//                             range; any clamp in a packet raises ovf
//                 undefined : accumulator wraps modulo 2^ACC_W, ovf tied to 0
// -----------------------------------------------------------------------------
module psmac_acc #(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [8*LANES-1:0]      ip,
  input  logic [8*LANES-1:0]      wt,
  input  logic [1:0]              mode,
  input  logic                    sgn_ip,
  input  logic                    sgn_wt,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] acc_out,
  output logic                    ovf
);

  localparam int LW = 18;                               // lane sum width
  localparam int BW = LW + $clog2(LANES);               // beat sum width

  typedef enum logic [1:0] {
    MODE_8B = 2'b00,
    MODE_4B = 2'b01,
    MODE_2B = 2'b10
  } mode_e;

  // Sum of all sub-field products of one lane. Every sub-field is extended to
  // 9 bits so the same signed multiply serves all three precisions.
  function automatic logic signed [LW-1:0] lane_sum(
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [1:0] m,
    input logic       sa,
    input logic       sb
  );
    logic signed [8:0]    ea;
    logic signed [8:0]    eb;
    logic signed [LW-1:0] s;
    s = '0;
    case (m)
      MODE_4B: begin
        for (int k = 0; k < 2; k++) begin
          ea = {{5{sa & a[4*k+3]}}, a[4*k +: 4]};
          eb = {{5{sb & b[4*k+3]}}, b[4*k +: 4]};
          s  = s + LW'(ea) * LW'(eb);
        end
      end
      MODE_2B: begin
        for (int k = 0; k < 4; k++) begin
          ea = {{7{sa & a[2*k+1]}}, a[2*k +: 2]};
          eb = {{7{sb & b[2*k+1]}}, b[2*k +: 2]};
          s  = s + LW'(ea) * LW'(eb);
        end
      end
      default: begin                                    // 8b and reserved 11
        ea = {sa & a[7], a};
        eb = {sb & b[7], b};
        s  = LW'(ea) * LW'(eb);
      end
    endcase
    return s;
  endfunction

  // Global stall: everything advances together or not at all.
  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------------------------------------------------------- S1 ------
  logic signed [LW-1:0] lane_d [LANES];
  logic signed [LW-1:0] s1_sum [LANES];
  logic                 s1_valid, s1_last;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      lane_d[i] = lane_sum(ip[8*i +: 8], wt[8*i +: 8], mode, sgn_ip, sgn_wt);
    end
  end

  // ---------------------------------------------------------------- S2 ------
  logic signed [BW-1:0] beat_d;
  logic signed [BW-1:0] s2_beat;
  logic                 s2_valid, s2_last;

  // NOTE: combinational blocks assign a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    beat_d = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_d = beat_d + BW'(s1_sum[i]);
    end
  end

  // ---------------------------------------------------------------- S3 ------
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;

`ifdef PSMAC_SAT_EN
  // One guard bit above the wider of accumulator and beat sum makes the raw
  // sum exact, so the range test below is a plain signed compare.
  localparam int SW = ((ACC_W > BW) ? ACC_W : BW) + 1;
  localparam logic signed [SW-1:0] SUM_MAX = {{(SW-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SW-1:0] SUM_MIN = {{(SW-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [SW-1:0] sum_full;
  logic                 clamp;
  logic                 sticky;

  always_comb begin
    sum_full = SW'(acc) + SW'(s2_beat);
    clamp    = 1'b0;
    acc_next = sum_full[ACC_W-1:0];
    if (sum_full > SUM_MAX) begin
      acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      clamp    = 1'b1;
    end else if (sum_full < SUM_MIN) begin
      acc_next = {1'b1, {(ACC_W-1){1'b0}}};
      clamp    = 1'b1;
    end
  end

  // Sticky flag collects clamps of the packet; it reaches ovf with the result
  // and restarts for the next packet on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= 1'b0;
      ovf    <= 1'b0;
    end else if (en && s2_valid) begin
      if (s2_last) begin
        ovf    <= sticky | clamp;
        sticky <= 1'b0;
      end else begin
        sticky <= sticky | clamp;
      end
    end
  end
`else
  always_comb begin
    acc_next = acc + ACC_W'(s2_beat);                  // wraps modulo 2^ACC_W
  end

  assign ovf = 1'b0;
`endif

  // ------------------------------------------------------- pipeline regs ----
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: datapath registers are reset too, not just the valids, so a reset
      // mid-packet leaves no stale partial sums and acc_out reads 0 at once.
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_sum    <= '{default: '0};
      s2_valid  <= 1'b0;
      s2_last   <= 1'b0;
      s2_beat   <= '0;
      acc       <= '0;
      acc_out   <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_last   <= in_last;
      s1_sum    <= lane_d;
      s2_valid  <= s1_valid;
      s2_last   <= s1_last;
      s2_beat   <= beat_d;
      // en implies any held result is being consumed on this edge, so
      // out_valid only stays high if a new last beat replaces it.
      out_valid <= s2_valid && s2_last;
      if (s2_valid) begin
        if (s2_last) begin
          acc_out <= acc_next;
          acc     <= '0;
        end else begin
          acc     <= acc_next;
        end
      end
    end
  end

endmodule

// File: doc/psmac_acc.md
# psmac_acc

Parametrised precision-scalable multiply-accumulate engine and successor to the fixed 32-bit, 2b/4b/8b single-cycle MAC. It multiplies LANES byte-lanes of activations by weights at a run-time selectable precision: one 8b×8b, two 4b×4b, or four 2b×2b products per lane. It reduces all products of a beat into one sum and accumulates beats into packets delimited by `in_last`. Valid/ready handshakes on input and output let it sit between the operand fetch buffer and the output writeback stage.

## Interface
- `LANES`, 4, number of 8-bit lanes (≥1)
- `ACC_W`, 32, accumulator and result width in bits (≥ 20 + clog2(LANES) is not required; narrower values rely on saturation/wrap)
- `clk` input 1 — single clock, rising edge
- `rst_n` input 1 — reset, asynchronous assert, active-low
- `in_valid` input 1 — input beat valid
- `in_ready` output 1 — engine can accept a beat
- `ip` input 8*LANES — activation operands, lane i = `ip[8i+7:8i]`
- `wt` input 8*LANES — weight operands, same packing
- `mode` input 2 — 00 = 8b, 01 = 4b, 10 = 2b, 11 = reserved (treated as 8b)
- `sgn_ip` input 1 — activation sub-fields signed (two's complement) when 1
- `sgn_wt` input 1 — weight sub-fields signed when 1
- `in_last` input 1 — beat closes the current packet
- `out_valid` output 1 — result valid
- `out_ready` input 1 — consumer accepts the result
- `acc_out` output ACC_W — signed packet result
- `ovf` output 1 — saturation occurred in this packet

## Operation
- Beat accepted on a rising edge with `in_valid && in_ready`. `mode`, `sgn_ip`, `sgn_wt` and `in_last` are captured per beat and travel with it. Mixed modes within one packet are legal.
- Products per lane:
  - 8b mode: whole byte × whole byte.
  - 4b mode: nibble k of `ip` × nibble k of `wt`, k = 0..1, summed.
  - 2b mode: crumb k × crumb k, k = 0..3, summed.
- Each sub-field is sign- or zero-extended per `sgn_ip`/`sgn_wt` before multiplying.
- Widths: lane sum is 18 bits signed. Beat sum is 18 + clog2(LANES) bits signed, sign-extended to ACC_W before accumulation. No precision is lost before the accumulator.
- Pipeline stages:
  - S1 registers the per-lane sums.
  - S2 registers the cross-lane beat sum.
  - S3 adds the beat sum to the running accumulator.
- On a beat with `in_last` at S3:
  - `acc_out` ← accumulator + beat sum, `ovf` ← sticky flag including this add, `out_valid` ← 1.
  - Running accumulator and sticky flag clear to 0 in the same edge.
- Stall: `en = !out_valid || out_ready`. All stage registers and the accumulator advance only when `en`=1; `in_ready = en`.
- Output handshake: `acc_out`/`ovf` hold stable while `out_valid && !out_ready`. Simultaneous `out_ready` and a new last-beat at S3 loads the new result with `out_valid` staying 1.
- Reset mid-packet: all in-flight beats and the partial accumulation are discarded.

## Timing
- Reset values: `out_valid`=0, `in_ready`=1 (after reset released), `acc_out`=0, `ovf`=0, all pipeline valids=0, accumulator=0.
- Latency: a last beat accepted on edge k gives `out_valid`=1 after edge k+2, with no stalls.
- Throughput: one beat per cycle while `out_ready`=1.
- A single-beat packet every cycle yields one result per cycle.
- `in_ready` is combinational from `out_valid` and `out_ready` only. There is no path from `in_valid`.

## Configuration
- `PSMAC_SAT_EN` defined:
  - Each accumulator add clamps to signed ACC_W max/min on overflow.
  - Any clamp in a packet sets the sticky flag, which reaches `ovf` with the result.
- Not defined:
  - Accumulator wraps modulo 2^ACC_W.
  - `ovf` is tied to 0.

## Test plan
- LANES=4, 8b, sgn both 1, `ip`=0x7F0302FF, `wt`=0x01010101, `in_last`=1 → `acc_out`=131 two edges after accept. Same beat with `sgn_ip`=0 → 387.
- 2b mode, `ip`=`wt`=0xFFFFFFFF: unsigned → 144; both signed → 16.
- 4b mode, both signed, `ip`=0x88888888, `wt`=0x77777777 → −448.
- Three back-to-back 8b beats each giving 131, last on the third, `out_ready`=0 for 5 cycles → single result 393. `out_valid` held, `acc_out` stable, `in_ready`=0 throughout. Result drains on the first `out_ready`=1 and the next packet proceeds.
- ACC_W=16, 8b signed, `ip`=`wt`=0x80808080, single last beat:
  - with `PSMAC_SAT_EN` → `acc_out`=32767, `ovf`=1;
  - without → `acc_out`=0, `ovf`=0.
- Two non-last beats accepted, `rst_n` pulsed low mid-cycle → outputs zero immediately. A following single last beat (131 case) returns exactly 131.
